// File: rtl/mask_pkg.sv
// Shared types and widths for the mask frame sequencer.
package mask_pkg;

    localparam int THR_W  = 32;
    localparam int FCNT_W = 16;
    localparam int FG_W   = 20;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    // Saturating increment so the foreground count sticks at all-ones instead of wrapping.
    function automatic logic [FG_W-1:0] sat_inc(input logic [FG_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/mask_scan_ctrl_if.sv
// Pixel-side bundle between the scan sequencer, sync controller and mask generator.
interface mask_scan_ctrl_if #(
    parameter int CW = 10
);

    logic                       pix_ready;
    logic                       read;
    logic [CW-1:0]              sync_x;
    logic [CW-1:0]              sync_y;
    logic [mask_pkg::THR_W-1:0] threshold;
    logic                       mg_valid;
    logic                       mg_mask;

    modport master (
        input  pix_ready, mg_valid, mg_mask,
        output read, sync_x, sync_y, threshold
    );

    modport slave (
        output pix_ready, mg_valid, mg_mask,
        input  read, sync_x, sync_y, threshold
    );

endinterface

// File: rtl/mask_raster_cnt.sv
// Raster x/y position counter: clear, advance-on-read and last-pixel flag.
module mask_raster_cnt #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CW       = 10
) (
    input  logic          clk_25,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          last
);

    localparam logic [CW-1:0] X_MAX = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] Y_MAX = CW'(V_ACTIVE - 1);

    logic [CW-1:0] x_reg;
    logic [CW-1:0] y_reg;

    assign x    = x_reg;
    assign y    = y_reg;
    assign last = (x_reg == X_MAX) && (y_reg == Y_MAX);

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (clr) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (adv) begin
            if (x_reg == X_MAX) begin
                x_reg <= '0;
                // Wrapping off the final pixel leaves the counter parked at the origin.
                y_reg <= last ? '0 : y_reg + 1'b1;
            end else begin
                x_reg <= x_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mask_scan_ctrl.sv
// Frame sequencer for the mask generator: raster walk, frame-stable threshold, completion stats.
// Optional foreground statistics enabled by defining MASK_SCAN_STATS_EN.
module mask_scan_ctrl
    import mask_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CW       = 10
) (
    input  logic              clk_25,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [THR_W-1:0]  thr_in,
    input  logic              thr_we,
    mask_scan_ctrl_if.master  pix,
    output logic              busy,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic [FG_W-1:0]   fg_count
);

    state_t             state_reg;
    state_t             state_next;
    logic [THR_W-1:0]   pending_reg;
    logic [THR_W-1:0]   thr_reg;
    logic [FCNT_W-1:0]  frame_cnt_reg;
    logic               rd;
    logic               cnt_clr;
    logic               abort_act;
    logic               last_pix;
    logic               frame_commit;
    logic [CW-1:0]      x_pos;
    logic [CW-1:0]      y_pos;

    assign abort_act    = abort && (state_reg != IDLE);
    // Abort also suppresses the strobe in its own cycle so no pixel is consumed mid-cancel.
    assign rd           = (state_reg == SCAN) && pix.pix_ready && !abort;
    assign cnt_clr      = (state_reg == ARM) || abort_act;
    assign frame_commit = (state_reg == DRAIN) && !abort;

    mask_raster_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .CW       (CW)
    ) u_raster (
        .clk_25 (clk_25),
        .rst    (rst),
        .clr    (cnt_clr),
        .adv    (rd),
        .x      (x_pos),
        .y      (y_pos),
        .last   (last_pix)
    );

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ARM;
            ARM:     state_next = SCAN;
            SCAN:    if (rd && last_pix) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort_act) begin
            state_next = IDLE;
        end
    end

    // Results are committed on the way into DONE so they are already visible during the pulse.
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            pending_reg   <= '0;
            thr_reg       <= '0;
            frame_cnt_reg <= '0;
        end else begin
            if (thr_we) begin
                pending_reg <= thr_in;
            end
            if (state_reg == ARM) begin
                thr_reg <= pending_reg;
            end
            if (frame_commit) begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
        end
    end

`ifdef MASK_SCAN_STATS_EN
    logic [FG_W-1:0] acc_reg;
    logic [FG_W-1:0] acc_next;
    logic [FG_W-1:0] fg_reg;
    logic            fg_hit;

    assign fg_hit   = ((state_reg == SCAN) || (state_reg == DRAIN)) && pix.mg_valid && !pix.mg_mask;
    assign acc_next = sat_inc(acc_reg, fg_hit);

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            fg_reg  <= '0;
        end else begin
            acc_reg <= (state_reg == ARM) ? '0 : acc_next;
            // The last pixel's result lands in DRAIN, so latch the updated sum.
            if (frame_commit) begin
                fg_reg <= acc_next;
            end
        end
    end

    assign fg_count = fg_reg;
`else
    logic unused_mg;
    assign unused_mg = pix.mg_valid ^ pix.mg_mask;
    assign fg_count  = '0;
`endif

    assign pix.read      = rd;
    assign pix.sync_x    = x_pos;
    assign pix.sync_y    = y_pos;
    assign pix.threshold = thr_reg;
    assign busy          = (state_reg != IDLE);
    assign frame_done    = (state_reg == DONE);
    assign frame_cnt     = frame_cnt_reg;

endmodule

// File: tb/tb_mask_scan_ctrl.sv
// Scoreboard bench for mask_scan_ctrl on a 4x3 raster; honours MASK_SCAN_STATS_EN like the RTL.
module tb_mask_scan_ctrl;
    import mask_pkg::*;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int CW = 10;
    localparam int NP = H * V;

    logic              clk_25 = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [THR_W-1:0]  thr_in;
    logic              thr_we;
    logic              busy;
    logic              frame_done;
    logic [FCNT_W-1:0] frame_cnt;
    logic [FG_W-1:0]   fg_count;

    mask_scan_ctrl_if #(.CW(CW)) pix ();

    mask_scan_ctrl #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .CW       (CW)
    ) dut (
        .clk_25     (clk_25),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .thr_in     (thr_in),
        .thr_we     (thr_we),
        .pix        (pix),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .fg_count   (fg_count)
    );

    always #20 clk_25 = ~clk_25;

    typedef struct {
        int          x;
        int          y;
        logic [31:0] thr;
    } rd_t;

    rd_t         rd_q[$];
    bit          mask_q[$];
    int          done_q[$];
    rd_t         mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_rd_cyc = -100;
    int          reads_total = 0;
    int          done_total = 0;
    int          done_fg = 0;
    bit          pend_v = 1'b0;
    bit          pend_m = 1'b1;
    int          exp_frames = 0;
    logic [31:0] model_pending = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk_25);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT strobes read or frame_done.
    always @(negedge clk_25) begin
        cyc++;
        pend_v = 1'b0;
        if (!rst && pix.read) begin
            if (rd_q.size() == 0) begin
                check("read_unexpected", 1, 0);
            end else begin
                mon_e = rd_q.pop_front();
                check("sync_x", pix.sync_x, mon_e.x);
                check("sync_y", pix.sync_y, mon_e.y);
                check("threshold", pix.threshold, mon_e.thr);
            end
            pend_v = 1'b1;
            pend_m = (mask_q.size() != 0) ? mask_q.pop_front() : 1'b1;
            last_rd_cyc = cyc;
            reads_total++;
            $display("read   x=%0d y=%0d thr=%0d", pix.sync_x, pix.sync_y, pix.threshold);
        end
        if (!rst && frame_done) begin
            if (done_q.size() == 0) begin
                check("frame_done_unexpected", 1, 0);
            end else begin
                done_fg = done_q.pop_front();
                check("done_latency", cyc - last_rd_cyc, 2);
                check("reads_missing", rd_q.size(), 0);
            end
            done_total++;
            $display("frame_done frame_cnt=%0d fg_count=%0d", frame_cnt, fg_count);
        end
    end

    // Mask generator model: one-cycle result latency behind each read.
    initial begin
        pix.mg_valid = 1'b0;
        pix.mg_mask  = 1'b1;
        forever begin
            @(posedge clk_25);
            #1;
            pix.mg_valid = pend_v;
            pix.mg_mask  = pend_m;
        end
    end

    task automatic do_start(input logic [31:0] t, input bit we, input bit fixed5);
        logic [31:0] eth;
        int          fg;
        bit          m;
        rd_t         r;
        fg  = 0;
        eth = we ? t : model_pending;
        if (we) model_pending = t;
        for (int yy = 0; yy < V; yy++) begin
            for (int xx = 0; xx < H; xx++) begin
                r.x = xx; r.y = yy; r.thr = eth;
                rd_q.push_back(r);
            end
        end
        for (int i = 0; i < NP; i++) begin
            m = fixed5 ? !((i % 2 == 0) && (i < 10)) : 1'($urandom_range(0, 1));
            mask_q.push_back(m);
            if (!m) fg++;
        end
`ifndef MASK_SCAN_STATS_EN
        fg = 0;
`endif
        done_q.push_back(fg);
        start = 1'b1; thr_in = t; thr_we = we;
        tick;
        start = 1'b0; thr_we = 1'b0; thr_in = $urandom;
        check("busy_arm", busy, 1);
    endtask

    // pmode: 0 = always ready, 1 = alternating, 2 = random.
    task automatic run_frame(input int pmode, input int start_at, input int thr_at, input logic [31:0] thr_val);
        int n;
        int base;
        n    = 0;
        base = done_total;
        while (done_total == base && n < 200) begin
            pix.pix_ready = (pmode == 0) ? 1'b1 : (pmode == 1) ? 1'(n % 2) : 1'($urandom_range(0, 1));
            start  = (n == start_at);
            thr_we = (n == thr_at);
            thr_in = thr_val;
            if (n == thr_at) model_pending = thr_val;
            tick;
            n++;
        end
        start = 1'b0; thr_we = 1'b0; pix.pix_ready = 1'b0;
        if (done_total == base) begin
            check("frame_timeout", 0, 1);
        end else begin
            exp_frames++;
            check("frame_cnt", frame_cnt, exp_frames[FCNT_W-1:0]);
            check("fg_count", fg_count, done_fg);
            check("busy_idle", busy, 0);
        end
    endtask

    task automatic run_abort(input int k);
        int n;
        int base;
        n    = 0;
        base = reads_total;
        pix.pix_ready = 1'b1;
        while (reads_total - base < k && n < 100) begin
            tick;
            n++;
        end
        check("abort_reach", reads_total - base, k);
        abort = 1'b1;
        #1;
        check("abort_read", pix.read, 0);
        @(posedge clk_25);
        #1;
        abort = 1'b0;
        rd_q.delete(); mask_q.delete(); done_q.delete();
        check("abort_busy", busy, 0);
        check("abort_x", pix.sync_x, 0);
        check("abort_y", pix.sync_y, 0);
        repeat (4) tick;
        pix.pix_ready = 1'b0;
        check("abort_frame_cnt", frame_cnt, exp_frames[FCNT_W-1:0]);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_read"}, pix.read, 0);
        check({tag, "_x"}, pix.sync_x, 0);
        check({tag, "_y"}, pix.sync_y, 0);
        check({tag, "_thr"}, pix.threshold, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_fcnt"}, frame_cnt, 0);
        check({tag, "_fg"}, fg_count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; thr_in = '0; thr_we = 1'b0;
        pix.pix_ready = 1'b0;
        repeat (3) tick;
        check_reset_vals("reset");
        rst = 1'b0;
        tick;

        // Idle with pixels offered: nothing may be read.
        pix.pix_ready = 1'b1;
        repeat (3) tick;
        pix.pix_ready = 1'b0;

        do_start(32'h55, 1'b1, 1'b0);
        run_frame(0, -1, -1, 0);

        do_start(32'h0, 1'b0, 1'b0);
        run_frame(1, -1, -1, 0);

        do_start(32'd100, 1'b1, 1'b0);
        run_frame(2, -1, 6, 32'd7);
        do_start(32'h0, 1'b0, 1'b0);
        run_frame(2, -1, -1, 0);

        do_start(32'd9, 1'b1, 1'b0);
        run_abort(5);
        do_start(32'h0, 1'b0, 1'b0);
        run_frame(0, -1, -1, 0);

        do_start(32'd3, 1'b1, 1'b1);
        run_frame(0, -1, -1, 0);

        do_start(32'd11, 1'b1, 1'b0);
        run_frame(0, 4, -1, 0);

        // Asynchronous reset mid-frame.
        do_start(32'd21, 1'b1, 1'b0);
        pix.pix_ready = 1'b1;
        repeat (6) tick;
        #5;
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        rd_q.delete(); mask_q.delete(); done_q.delete();
        exp_frames = 0;
        model_pending = '0;
        pix.pix_ready = 1'b0;
        repeat (2) tick;
        rst = 1'b0;
        tick;

        for (int i = 0; i < 4; i++) begin
            do_start($urandom, 1'($urandom_range(0, 1)), 1'b0);
            run_frame(2, -1, -1, 0);
        end

        repeat (3) tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
